// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (port 0)
// and load/store (port 1); registers the winner's request and returns read data.
module mem_port_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             busy,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, next_state;
  logic   last_grant;
  logic   winner;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    winner = req1;
    if (req0 && req1) winner = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req0 || req1) next_state = BUSY;
      BUSY:    if (mem_ack)      next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= '0;
      last_grant <= 1'b1;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel       <= winner;
            mem_addr  <= winner ? addr1  : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            mem_we    <= winner ? we1    : we0;
            mem_req   <= 1'b1;
          end
        end
        BUSY: begin
          // Writes leave rdata holding the last read result.
          if (mem_ack) begin
            if (!mem_we) rdata <= mem_rdata;
            if (sel) done1 <= 1'b1;
            else     done0 <= 1'b1;
            mem_req    <= 1'b0;
            last_grant <= sel;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected completions,
// a monitor checks each done pulse against the queue head.
module tb_mem_port_arbiter;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1, we0, we1;
  logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
  logic             done0, done1, sel, busy, mem_req, mem_we, mem_ack;
  logic [WIDTH-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit               port;
    logic [WIDTH-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               wait_cycles = 0;
  logic [WIDTH-1:0] rd_value = '0;
  bit               spurious = 1'b0;
  bit               prev_done = 1'b0;

  mem_port_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .sel(sel), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Memory model: acks after wait_cycles of mem_req; junk data outside a request.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = spurious;
      mem_rdata = 32'hBAD0BAD0;
      if (mem_req) begin
        mem_rdata = rd_value;
        if (wait_cnt >= wait_cycles) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done0 || done1) begin
        check_output("done_single_cycle", 32'(prev_done), 32'd0);
        check_output("done_onehot", 32'(done0 & done1), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
        end else begin
          e = exp_q.pop_front();
          check_output("done_port", 32'(done1), 32'(e.port));
          check_output("sel", 32'(sel), 32'(e.port));
          check_output("rdata", rdata, e.rdata);
        end
      end
      prev_done = done0 | done1;
    end
  end

  task automatic push_exp(input bit port, input logic [WIDTH-1:0] data);
    exp_t e;
    e.port  = port;
    e.rdata = data;
    exp_q.push_back(e);
  endtask

  // kind 0: mem_req, 1: any done, 2: done1
  task automatic wait_signal(input string name, input int kind);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      case (kind)
        0:       hit = mem_req;
        1:       hit = done0 | done1;
        default: hit = done1;
      endcase
      if (hit) break;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("[TB] FAIL timeout_%s: got no event expected event within 100 cycles", name);
    end
  endtask

  task automatic apply_stimulus(input bit port, input logic [WIDTH-1:0] addr,
                                input logic [WIDTH-1:0] wdata, input bit we, input int waits,
                                input logic [WIDTH-1:0] mem_val, input logic [WIDTH-1:0] exp_rdata);
    int busy_cycles;
    bit got;
    @(negedge clk);
    wait_cycles = waits;
    rd_value    = mem_val;
    push_exp(port, exp_rdata);
    if (port) begin
      addr1 = addr; wdata1 = wdata; we1 = we; req1 = 1'b1;
    end else begin
      addr0 = addr; wdata0 = wdata; we0 = we; req0 = 1'b1;
    end
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (port ? done1 : done0) got = 1'b1;
      else if (mem_req) begin
        busy_cycles++;
        check_output("mem_addr", mem_addr, addr);
        check_output("mem_wdata", mem_wdata, wdata);
        check_output("mem_we", 32'(mem_we), 32'(we));
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("[TB] FAIL timeout_done: got no done expected done%0d", port);
    end
    check_output("busy_cycles", 32'(busy_cycles), 32'(waits + 1));
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    int t[4];
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clk);
    check_output("rst_mem_req", 32'(mem_req), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_done0", 32'(done0), 32'd0);
    check_output("rst_done1", 32'(done1), 32'd0);
    check_output("rst_rdata", rdata, 32'd0);
    check_output("rst_sel", 32'(sel), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a long port 1 read abandons it.
    @(negedge clk);
    wait_cycles = 5;
    rd_value = 32'h11111111;
    addr1 = 32'h00000040;
    req1 = 1'b1;
    wait_signal("mid_busy_req", 0);
    check_output("pre_rst_sel", 32'(sel), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort_mem_req", 32'(mem_req), 32'd0);
    check_output("abort_done0", 32'(done0), 32'd0);
    check_output("abort_done1", 32'(done1), 32'd0);
    check_output("abort_rdata", rdata, 32'd0);
    check_output("abort_sel", 32'(sel), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention straight after reset: grants alternate starting with port 0.
    @(negedge clk);
    wait_cycles = 0;
    rd_value = 32'hC0DE0001;
    addr0 = 32'h00000100; wdata0 = '0; we0 = 1'b0;
    addr1 = 32'h00000200; wdata1 = '0; we1 = 1'b0;
    push_exp(1'b0, 32'hC0DE0001);
    push_exp(1'b1, 32'hC0DE0001);
    push_exp(1'b0, 32'hC0DE0001);
    push_exp(1'b1, 32'hC0DE0001);
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_signal("contention_done", 1);
      t[k] = cyc;
      if (k > 0) check_output("done_spacing", 32'(t[k] - t[k-1]), 32'd3);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    apply_stimulus(1'b0, 32'h00400000, 32'h0, 1'b0, 0, 32'h8C080004, 32'h8C080004);
    apply_stimulus(1'b1, 32'h10010000, 32'hDEADBEEF, 1'b1, 3, 32'hFFFF0000, 32'h8C080004);

    // mem_ack held high through idle, response and idle again.
    @(negedge clk);
    spurious = 1'b1;
    repeat (5) @(negedge clk);
    check_output("spur_idle_busy", 32'(busy), 32'd0);
    check_output("spur_idle_rdata", rdata, 32'h8C080004);
    apply_stimulus(1'b0, 32'h00000300, 32'h0, 1'b0, 0, 32'h13579BDF, 32'h13579BDF);
    repeat (4) @(negedge clk);
    check_output("spur_resp_busy", 32'(busy), 32'd0);
    check_output("spur_resp_rdata", rdata, 32'h13579BDF);
    spurious = 1'b0;

    // Port 1 drops req during BUSY; the transaction still completes.
    @(negedge clk);
    wait_cycles = 4;
    rd_value = 32'h2468ACE0;
    addr1 = 32'h00000500; we1 = 1'b0;
    push_exp(1'b1, 32'h2468ACE0);
    req1 = 1'b1;
    wait_signal("drop_req", 0);
    req1 = 1'b0;
    wait_signal("drop_done1", 2);

    apply_stimulus(1'b1, 32'h10010040, 32'h12345678, 1'b1, 0, 32'hFFFFFFFF, 32'h2468ACE0);
    apply_stimulus(1'b0, 32'h10010040, 32'h0, 1'b0, 1, 32'h12345678, 32'h12345678);

    repeat (3) @(negedge clk);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
